// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - coprocessor opcodes, issuer FSM states and opcode class helpers
package coproc_pkg;

    localparam logic [3:0] OP_READ       = 4'b0001;
    localparam logic [3:0] OP_WRITE      = 4'b0010;
    localparam logic [3:0] OP_CONV       = 4'b0011;
    localparam logic [3:0] OP_CONV_TRSP  = 4'b0100;
    localparam logic [3:0] OP_CONV_ROB   = 4'b0101;
    localparam logic [3:0] OP_PHOTO_CONV = 4'b1110;
    localparam logic [3:0] OP_READ_IMAGE = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ARM,
        ST_BUSY,
        ST_HOLD
    } state_t;

    // Ops that return a word through the response queue
    function automatic logic is_rsp_op(input logic [3:0] op);
        return (op == OP_READ) || (op == OP_READ_IMAGE);
    endfunction

    // Ops presented as a held level rather than an activate pulse
    function automatic logic is_level_op(input logic [3:0] op);
        return (op == OP_PHOTO_CONV) || (op == OP_READ_IMAGE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - count-based synchronous FIFO with first-word-fall-through output
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_count == FULL_CNT);
    assign empty    = (r_count == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at power-of-two depth; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/coproc_cmd_issuer.sv
// rtl/coproc_cmd_issuer.sv - queued coprocessor instruction issuer; optional watchdog via COPROC_TIMEOUT_EN
module coproc_cmd_issuer
    import coproc_pkg::*;
#(
    parameter int CMD_DEPTH      = 8,
    parameter int RSP_DEPTH      = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] cp_instruction,
    output logic [1:0]  cp_activate,
    input  logic        cp_wait,
    input  logic [31:0] cp_data_read,
    output logic        busy,
    output logic        error
);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_op;
    logic [31:0] r_instr;
    logic [1:0]  r_act;
    logic [15:0] r_hold_cnt;

    logic [31:0] w_cmd_head;
    logic        w_cmd_full;
    logic        w_cmd_empty;
    logic        w_cmd_pop;
    logic        w_rsp_full;
    logic        w_rsp_empty;
    logic        w_rsp_push;
    logic        w_hold_last;
    logic        w_tmo_hit;

    assign cmd_ready      = !w_cmd_full;
    assign rsp_valid      = !w_rsp_empty;
    assign cp_instruction = r_instr;
    assign cp_activate    = r_act;
    assign busy           = (r_state != ST_IDLE);
    assign w_hold_last    = (r_hold_cnt == HOLD_LAST);

    // Response space is reserved at pop time so a response push can never overflow
    assign w_cmd_pop = (r_state == ST_IDLE) && !w_cmd_empty && !cp_wait &&
                       (!is_rsp_op(w_cmd_head[3:0]) || !w_rsp_full);

    assign w_rsp_push = !w_tmo_hit &&
                        (((r_state == ST_BUSY) && !cp_wait && (r_op == OP_READ)) ||
                         ((r_state == ST_HOLD) && w_hold_last && (r_op == OP_READ_IMAGE)));

    sync_fifo #(.WIDTH(32), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (cmd_data),
        .pop       (w_cmd_pop),
        .pop_data  (w_cmd_head),
        .full      (w_cmd_full),
        .empty     (w_cmd_empty)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_rsp_push),
        .push_data (cp_data_read),
        .pop       (rsp_ready),
        .pop_data  (rsp_data),
        .full      (w_rsp_full),
        .empty     (w_rsp_empty)
    );

`ifdef COPROC_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_tmo;
    logic        r_error;
    logic        w_tmo_run;

    assign w_tmo_run = (r_state == ST_ARM) || (r_state == ST_BUSY) || (r_state == ST_HOLD);
    assign w_tmo_hit = w_tmo_run && (r_tmo == TMO_LAST);
    assign error     = r_error;

    // Watchdog restarts on every state entry; ARM->BUSY is the only waiting-to-waiting move
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            if (!w_tmo_run || w_tmo_hit || ((r_state == ST_ARM) && cp_wait)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 32'd1;
            end
            if (w_tmo_hit) r_error <= 1'b1;
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign error        = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // Issue FSM; instruction and activate are registered so the bus never glitches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_instr    <= '0;
            r_act      <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_instr <= '0;
                    r_act   <= '0;
                    if (w_cmd_pop) begin
                        r_op    <= w_cmd_head[3:0];
                        r_instr <= w_cmd_head;
                        if (is_level_op(w_cmd_head[3:0])) begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_act   <= 2'b01;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_act   <= '0;
                    r_state <= ST_ARM;
                end
                ST_ARM: begin
                    if (cp_wait) r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (!cp_wait) begin
                        r_instr <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (w_hold_last) begin
                        r_instr <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                default: begin
                    r_instr <= '0;
                    r_act   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_tmo_hit) begin
                r_instr <= '0;
                r_act   <= '0;
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_coproc_cmd_issuer.sv
// tb/tb_coproc_cmd_issuer.sv - directed self-checking bench for coproc_cmd_issuer with a coprocessor model
module tb_coproc_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] cp_instruction;
    logic [1:0]  cp_activate;
    logic        cp_wait;
    logic [31:0] cp_data_read;
    logic        busy;
    logic        error;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          wait_len;
    logic        model_stuck;
    logic [31:0] model_base;
    logic [31:0] model_data;
    int          hs_idx;
    int          hs_mark;

    always #5 clk = ~clk;

    coproc_cmd_issuer u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .cp_instruction (cp_instruction),
        .cp_activate    (cp_activate),
        .cp_wait        (cp_wait),
        .cp_data_read   (cp_data_read),
        .busy           (busy),
        .error          (error)
    );

    // Image RAM model: word at address a is {16'h0, a ^ 16'h5A5A}
    assign cp_data_read = (cp_instruction[3:0] == 4'hF) ?
                          {16'h0000, cp_instruction[19:4] ^ 16'h5A5A} : model_data;

    // Coprocessor handshake model: raise wait after an activate pulse, drop it wait_len cycles later
    initial begin
        cp_wait    = 1'b0;
        model_data = '0;
        hs_idx     = 0;
        forever begin
            @(negedge clk);
            if (cp_activate == 2'b01) begin
                @(posedge clk);
                #1;
                cp_wait    = 1'b1;
                model_data = model_base + 32'(hs_idx - hs_mark);
                hs_idx     = hs_idx + 1;
                repeat (wait_len) @(posedge clk);
                while (model_stuck) @(posedge clk);
                #1;
                cp_wait = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] d);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) chk("push_ready_timeout", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(input string tag, input logic [31:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_data"}, rsp_data, exp);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic watch(input int n, input logic [31:0] instr_val, output int act_cycles,
                         output int act_bad, output logic [31:0] act_instr, output int instr_cycles);
        act_cycles   = 0;
        act_bad      = 0;
        act_instr    = '0;
        instr_cycles = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cp_activate == 2'b01) begin
                act_cycles++;
                act_instr = cp_instruction;
            end
            if (cp_activate[1]) act_bad++;
            if (cp_instruction == instr_val) instr_cycles++;
        end
    endtask

    initial begin
        int          ac;
        int          ab;
        int          ic;
        int          k;
        logic [31:0] ai;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = '0;
        rsp_ready   = 1'b0;
        wait_len    = 2;
        model_stuck = 1'b0;
        model_base  = '0;
        hs_mark     = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_instr", cp_instruction, 32'd0);
        chk("rst_activate", {30'b0, cp_activate}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);

        // 1: WRITE handshake
        wait_len = 2;
        push_cmd(32'h0000_1232);
        watch(15, 32'h0000_1232, ac, ab, ai, ic);
        chk("t1_act_cycles", 32'(ac), 32'd1);
        chk("t1_act_instr", ai, 32'h0000_1232);
        chk("t1_act_bit1", 32'(ab), 32'd0);
        chk("t1_instr_cycles", 32'(ic), 32'd4);
        chk("t1_busy", {31'b0, busy}, 32'd0);
        chk("t1_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // 2: READ with 3-cycle busy window
        wait_len   = 3;
        model_base = 32'h0000_00AB;
        hs_mark    = hs_idx;
        push_cmd(32'h0000_0051);
        k = 0;
        while (!cp_wait && k < 50) begin @(negedge clk); k++; end
        chk("t2_wait_rise", {31'b0, cp_wait}, 32'd1);
        k = 0;
        while (cp_wait && k < 50) begin @(negedge clk); k++; end
        chk("t2_wait_fall", {31'b0, cp_wait}, 32'd0);
        chk("t2_rsp_not_yet", {31'b0, rsp_valid}, 32'd0);
        pop_rsp("t2_rsp", 32'h0000_00AB);
        @(negedge clk);
        chk("t2_rsp_drained", {31'b0, rsp_valid}, 32'd0);

        // 3: READ_IMAGE level op
        push_cmd(32'h0001_234F);
        watch(12, 32'h0001_234F, ac, ab, ai, ic);
        chk("t3_instr_cycles", 32'(ic), 32'd4);
        chk("t3_act_cycles", 32'(ac), 32'd0);
        chk("t3_act_bit1", 32'(ab), 32'd0);
        pop_rsp("t3_rsp", 32'h0000_486E);

        // 4: response queue back-pressure
        wait_len   = 1;
        model_base = 32'h0000_0100;
        hs_mark    = hs_idx;
        for (int i = 0; i < 9; i++) push_cmd(32'h0000_0001 | (32'(i) << 4));
        repeat (80) @(negedge clk);
        chk("t4_issued_8", 32'(hs_idx - hs_mark), 32'd8);
        watch(10, 32'hFFFF_FFFF, ac, ab, ai, ic);
        chk("t4_act_quiet", 32'(ac), 32'd0);
        chk("t4_busy_idle", {31'b0, busy}, 32'd0);
        chk("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        pop_rsp("t4_rsp0", 32'h0000_0100);
        repeat (20) @(negedge clk);
        chk("t4_issued_9", 32'(hs_idx - hs_mark), 32'd9);
        for (int i = 1; i < 9; i++) pop_rsp("t4_rspn", 32'h0000_0100 + 32'(i));
        @(negedge clk);
        chk("t4_drained", {31'b0, rsp_valid}, 32'd0);

        // 5: reset during BUSY
        wait_len = 20;
        push_cmd(32'h0000_0051);
        push_cmd(32'h0000_0002);
        k = 0;
        while (!cp_wait && k < 50) begin @(negedge clk); k++; end
        chk("t5_wait_rise", {31'b0, cp_wait}, 32'd1);
        @(negedge clk);
        hs_mark = hs_idx;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("t5_instr", cp_instruction, 32'd0);
        chk("t5_activate", {30'b0, cp_activate}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_error", {31'b0, error}, 32'd0);
        chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("t5_cmd_lost", 32'(hs_idx - hs_mark), 32'd0);
        chk("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("t5_wait_clear", {31'b0, cp_wait}, 32'd0);

`ifdef COPROC_TIMEOUT_EN
        // 6: watchdog on a stuck busy line
        wait_len    = 1;
        model_stuck = 1'b1;
        push_cmd(32'h0000_0051);
        k = 0;
        while (!error && k < 5000) begin @(negedge clk); k++; end
        chk("t6_error", {31'b0, error}, 32'd1);
        chk("t6_cycles_min", {31'b0, (k >= 4090)}, 32'd1);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_no_rsp", {31'b0, rsp_valid}, 32'd0);
        model_stuck = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_error_sticky", {31'b0, error}, 32'd1);
`else
        chk("t6_error_tied", {31'b0, error}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
